// File: rtl/led_ctrl_pkg.sv
// Shared definitions for the LED burst arbiter: mode codes, FSM states and
// the 4-step LED pattern table.
package led_ctrl_pkg;

    localparam logic [1:0] SOLID = 2'b00;
    localparam logic [1:0] BLINK = 2'b01;
    localparam logic [1:0] ALT   = 2'b10;
    localparam logic [1:0] HEART = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    function automatic logic [1:0] led_pattern(input logic [1:0] mode, input logic [1:0] step);
        logic [1:0] pat;
        case (mode)
            SOLID:   pat = 2'b11;
            BLINK:   pat = step[0] ? 2'b00 : 2'b11;
            ALT:     pat = step[0] ? 2'b10 : 2'b01;
            default: pat = (step == 2'd0) ? 2'b11 : 2'b00;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Step prescaler: counts 0..TICK_DIV-1 and flags the terminal count.
// A synchronous clear restarts the count so each phase begins on a full step.
module led_tick_gen #(
    parameter int TICK_DIV = 12_500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr || (cnt_q == CNT_MAX)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == CNT_MAX);

endmodule

// File: rtl/led_burst_arbiter.sv
// Round-robin owner of the two user LEDs: each granted requester plays one
// burst of its selected pattern, followed by a dark gap step.
module led_burst_arbiter
    import led_ctrl_pkg::*;
#(
    parameter int N_REQ    = 3,
    parameter int TICK_DIV = 12_500_000,
    parameter int REPS     = 2
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [2*N_REQ-1:0] mode,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   done,
    output logic               busy,
    output logic [1:0]         led
);

    localparam int IDX_W  = $clog2(N_REQ);
    localparam int STEP_W = $clog2(4 * REPS);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(4 * REPS - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_REQ - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [1:0]         mode_q, mode_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic               busy_q, busy_d;
    logic [1:0]         led_q, led_d;

    logic               tick;
    logic               tick_clr;
    logic               win_vld;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   ptr_next;
    int                 win_sum;

    led_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk  (sys_clk),
        .rst  (sys_rst),
        .clr  (tick_clr),
        .tick (tick)
    );

    // Search starts at ptr and wraps, so the last served requester goes to the back.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        win_sum = 0;
        for (int i = 0; i < N_REQ; i++) begin
            win_sum = i + int'(ptr_q);
            if (win_sum >= N_REQ) begin
                win_sum = win_sum - N_REQ;
            end
            if (!win_vld && req[win_sum]) begin
                win_vld = 1'b1;
                win_idx = IDX_W'(win_sum);
            end
        end
    end

    assign ptr_next = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        idx_d    = idx_q;
        mode_d   = mode_q;
        step_d   = step_q;
        gnt_d    = gnt_q;
        done_d   = '0;
        led_d    = 2'b00;
        tick_clr = 1'b0;

        case (state_q)
            IDLE: begin
                tick_clr = 1'b1;
                if (win_vld) begin
                    state_d         = RUN;
                    idx_d           = win_idx;
                    mode_d          = mode[2*int'(win_idx) +: 2];
                    step_d          = '0;
                    gnt_d           = '0;
                    gnt_d[win_idx]  = 1'b1;
                    led_d           = led_pattern(mode_d, 2'd0);
                end
            end
            RUN: begin
                // Completion is checked first so it wins over a coincident withdrawal.
                if (tick && (step_q == STEP_LAST)) begin
                    state_d        = GAP;
                    done_d[idx_q]  = 1'b1;
                    gnt_d          = '0;
                    ptr_d          = ptr_next;
                    tick_clr       = 1'b1;
                end else if (!req[idx_q]) begin
                    state_d  = GAP;
                    gnt_d    = '0;
                    ptr_d    = ptr_next;
                    tick_clr = 1'b1;
                end else begin
                    if (tick) begin
                        step_d = step_q + 1'b1;
                    end
                    led_d = led_pattern(mode_q, step_d[1:0]);
                end
            end
            GAP: begin
                if (tick) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            mode_q  <= SOLID;
            step_q  <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            led_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
            step_q  <= step_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            led_q   <= led_d;
        end
    end

    assign gnt  = gnt_q;
    assign done = done_q;
    assign busy = busy_q;
    assign led  = led_q;

endmodule

// File: tb/tb_led_burst_arbiter.sv
// Directed bench for led_burst_arbiter: per-cycle expected outputs are queued
// as stimulus is planned and popped/compared one clock at a time.
module tb_led_burst_arbiter;

    localparam int N_REQ    = 3;
    localparam int TICK_DIV = 4;
    localparam int REPS     = 2;
    localparam int BURST    = 4 * REPS * TICK_DIV;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic [2:0] req     = 3'b000;
    logic [5:0] mode    = 6'b000000;
    logic [2:0] gnt;
    logic [2:0] done;
    logic       busy;
    logic [1:0] led;

    typedef struct packed {
        logic [2:0] gnt;
        logic [2:0] done;
        logic       busy;
        logic [1:0] led;
    } obs_t;

    obs_t  exp_q[$];
    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    string tag   = "reset";

    led_burst_arbiter #(
        .N_REQ    (N_REQ),
        .TICK_DIV (TICK_DIV),
        .REPS     (REPS)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .req     (req),
        .mode    (mode),
        .gnt     (gnt),
        .done    (done),
        .busy    (busy),
        .led     (led)
    );

    always #5 sys_clk = ~sys_clk;

    // Pattern rows written step 0 first (leftmost pair).
    function automatic logic [1:0] pat(input logic [1:0] m, input int s);
        logic [7:0] row;
        case (m)
            2'b00:   row = 8'b11_11_11_11;
            2'b01:   row = 8'b11_00_11_00;
            2'b10:   row = 8'b01_10_01_10;
            default: row = 8'b11_00_00_00;
        endcase
        return row[7-2*s -: 2];
    endfunction

    task automatic push_idle(input int n);
        obs_t e;
        for (int i = 0; i < n; i++) begin
            e = '{gnt: 3'b000, done: 3'b000, busy: 1'b0, led: 2'b00};
            exp_q.push_back(e);
        end
    endtask

    task automatic push_burst(input int idx, input logic [1:0] m, input int from, input int upto);
        obs_t e;
        for (int c = from; c < upto; c++) begin
            e.gnt  = 3'b001 << idx;
            e.done = 3'b000;
            e.busy = 1'b1;
            e.led  = pat(m, (c / TICK_DIV) % 4);
            exp_q.push_back(e);
        end
    endtask

    // Gap after a burst: TICK_DIV dark busy cycles (done only in the first
    // when didx >= 0), then one IDLE cycle.
    task automatic push_gap(input int didx);
        obs_t e;
        for (int c = 0; c < TICK_DIV; c++) begin
            e.gnt  = 3'b000;
            e.done = (c == 0 && didx >= 0) ? (3'b001 << didx) : 3'b000;
            e.busy = 1'b1;
            e.led  = 2'b00;
            exp_q.push_back(e);
        end
        push_idle(1);
    endtask

    task automatic run_q();
        obs_t e;
        obs_t o;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(posedge sys_clk);
            #1;
            o = {gnt, done, busy, led};
            total++;
            assert (o === e) else begin
                bad++;
                $error("FAIL %s cyc=%0d observed gnt/done/busy/led=%b required=%b", tag, cyc, o, e);
            end
            cyc++;
        end
    endtask

    task automatic check_now(input string t, input obs_t e);
        obs_t o;
        o = {gnt, done, busy, led};
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed gnt/done/busy/led=%b required=%b", t, o, e);
        end
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
    endtask

    initial begin
        obs_t zero;
        zero = '{gnt: 3'b000, done: 3'b000, busy: 1'b0, led: 2'b00};

        // 1: reset held, then released with no requests
        tag = "reset_hold";
        push_idle(3);
        run_q();
        sys_rst = 1'b0;
        tag = "idle_no_req";
        push_idle(4);
        run_q();

        // 2: single requester BLINK, full burst, gap, regrant, then withdraw
        tag = "blink_burst";
        mode = 6'b00_00_01;
        req  = 3'b001;
        push_burst(0, 2'b01, 0, BURST);
        push_gap(0);
        push_burst(0, 2'b01, 0, 1);
        run_q();
        req = 3'b000;
        tag = "withdraw_first_cycle";
        push_gap(-1);
        push_idle(2);
        run_q();

        // 3: all requesting, round-robin 0,1,2,0
        do_reset();
        tag = "rr_all";
        mode = 6'b11_10_00;
        req  = 3'b111;
        push_burst(0, 2'b00, 0, BURST);
        push_gap(0);
        push_burst(1, 2'b10, 0, BURST);
        push_gap(1);
        push_burst(2, 2'b11, 0, BURST);
        push_gap(2);
        push_burst(0, 2'b00, 0, BURST);
        push_gap(0);
        run_q();

        // 4: requester 1 withdraws at clock 10 of its ALT burst
        tag = "abort_alt";
        push_burst(1, 2'b10, 0, 10);
        run_q();
        req = 3'b101;
        push_gap(-1);
        tag = "after_abort_grant2";
        push_burst(2, 2'b11, 0, 4);
        run_q();
        req = 3'b000;
        tag = "abort_heart";
        push_gap(-1);
        run_q();

        // 5: mode change mid-burst is ignored
        do_reset();
        tag = "mode_latched";
        mode = 6'b00_00_00;
        req  = 3'b001;
        push_burst(0, 2'b00, 0, 8);
        run_q();
        mode = 6'b00_00_11;
        push_burst(0, 2'b00, 8, BURST);
        run_q();
        req = 3'b010;
        tag = "gap_then_req1";
        push_gap(0);
        push_burst(1, 2'b00, 0, 15);
        run_q();

        // 6: asynchronous reset mid-burst, ptr restarts at requester 0
        #3;
        sys_rst = 1'b1;
        #1;
        check_now("async_reset", zero);
        req = 3'b011;
        @(posedge sys_clk);
        #1;
        check_now("reset_held_edge", zero);
        sys_rst = 1'b0;
        tag = "post_reset_grant0";
        push_burst(0, 2'b11, 0, 8);
        run_q();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
